// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, opcode, mux-select and ALU encodings for the accumulator CPU.
package cpu_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_F_MAR, S_F_WAIT, S_F_IR, S_DECODE,
      S_X_MAR, S_X_WAIT, S_X_MBR, S_X_ACC, S_X_STORE, S_HALTED
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUBT  = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'h7;
   localparam logic [3:0] OP_SKIP  = 4'h8;
   localparam logic [3:0] OP_JUMP  = 4'h9;
   localparam logic [3:0] OP_CLEAR = 4'hA;

   localparam logic [1:0] ACC_MBR  = 2'b00;
   localparam logic [1:0] ACC_ALU  = 2'b01;
   localparam logic [1:0] ACC_ZERO = 2'b10;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;

   localparam logic [1:0] SKIP_NEG   = 2'b00;
   localparam logic [1:0] SKIP_ZERO  = 2'b01;
   localparam logic [1:0] SKIP_POS   = 2'b10;
   localparam logic [1:0] SKIP_NEVER = 2'b11;

   function automatic logic is_legal(input logic [3:0] op);
      return op inside {OP_LOAD, OP_STORE, OP_ADD, OP_SUBT, OP_HALT, OP_SKIP, OP_JUMP, OP_CLEAR};
   endfunction

endpackage

// File: rtl/skip_eval.sv
// skip_eval: SKIPCOND predicate on the accumulator sign/zero state.
module skip_eval #(
   parameter int DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] acc,
   input  logic [1:0]            cond,
   output logic                  skip
);
   import cpu_pkg::*;

   logic neg;
   logic zero;

   assign neg  = acc[DATA_WIDTH-1];
   assign zero = acc == '0;
   assign skip = cond == SKIP_NEG  ? neg :
                 cond == SKIP_ZERO ? zero :
                 cond == SKIP_POS  ? !neg && !zero : 1'b0;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch-decode-execute FSM driving the accumulator CPU datapath controls.
module control_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_FIELD = 12
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  run,
   input  logic [DATA_WIDTH-1:0] ir,
   input  logic [DATA_WIDTH-1:0] acc,
   output logic                  pc_write,
   output logic                  pc_src,
   output logic                  mar_write,
   output logic                  mar_src,
   output logic                  mbr_write,
   output logic                  mbr_src,
   output logic                  ir_write,
   output logic                  acc_write,
   output logic [1:0]            acc_src,
   output logic [3:0]            alu_opcode,
   output logic                  mem_write_enable,
   output logic                  halted,
   output logic                  illegal_opcode
);
   import cpu_pkg::*;

   state_t     state;
   state_t     state_next;
   logic [3:0] opcode;
   logic       skip;
   logic       startable;
   logic       unused;

   assign opcode    = ir[DATA_WIDTH-1 -: 4];
   assign startable = state == S_IDLE || state == S_HALTED;
   assign unused    = ^ir[ADDR_FIELD-3:0];

   skip_eval #(.DATA_WIDTH(DATA_WIDTH)) u_skip (
      .acc  (acc),
      .cond (ir[ADDR_FIELD-1 -: 2]),
      .skip (skip)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         illegal_opcode <= 1'b0;
      end else begin
         state <= state_next;
         if (run && startable)
            illegal_opcode <= 1'b0;
         else if (state == S_DECODE && !is_legal(opcode))
            illegal_opcode <= 1'b1;
      end
   end

   always_comb begin
      state_next       = state;
      pc_write         = 1'b0;
      pc_src           = 1'b0;
      mar_write        = 1'b0;
      mar_src          = 1'b0;
      mbr_write        = 1'b0;
      mbr_src          = 1'b0;
      ir_write         = 1'b0;
      acc_write        = 1'b0;
      acc_src          = ACC_MBR;
      alu_opcode       = ALU_ADD;
      mem_write_enable = 1'b0;
      halted           = 1'b0;
      case (state)
         S_IDLE:   state_next = run ? S_F_MAR : S_IDLE;
         S_F_MAR: begin
            mar_write  = 1'b1;
            state_next = S_F_WAIT;
         end
         S_F_WAIT: state_next = S_F_IR;
         S_F_IR: begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_ADD, OP_SUBT: state_next = S_X_MAR;
               // STORE passes through X_WAIT so the memory write never follows a MAR load directly
               OP_STORE: begin
                  mar_write  = 1'b1;
                  mar_src    = 1'b1;
                  mbr_write  = 1'b1;
                  mbr_src    = 1'b1;
                  state_next = S_X_WAIT;
               end
               OP_JUMP: begin
                  pc_write   = 1'b1;
                  pc_src     = 1'b1;
                  state_next = S_F_MAR;
               end
               OP_CLEAR: begin
                  acc_write  = 1'b1;
                  acc_src    = ACC_ZERO;
                  state_next = S_F_MAR;
               end
               OP_SKIP: begin
                  pc_write   = skip;
                  state_next = S_F_MAR;
               end
               default:  state_next = S_HALTED;
            endcase
         end
         S_X_MAR: begin
            mar_write  = 1'b1;
            mar_src    = 1'b1;
            state_next = S_X_WAIT;
         end
         S_X_WAIT: state_next = opcode == OP_STORE ? S_X_STORE : S_X_MBR;
         S_X_MBR: begin
            mbr_write  = 1'b1;
            state_next = S_X_ACC;
         end
         S_X_ACC: begin
            acc_write  = 1'b1;
            acc_src    = opcode == OP_LOAD ? ACC_MBR : ACC_ALU;
            alu_opcode = opcode == OP_SUBT ? ALU_SUB : ALU_ADD;
            state_next = S_F_MAR;
         end
         S_X_STORE: begin
            mem_write_enable = 1'b1;
            state_next       = S_F_MAR;
         end
         S_HALTED: begin
            halted     = 1'b1;
            state_next = run ? S_F_MAR : S_HALTED;
         end
         default:  state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table, random and reset-corner checks of the control sequencer against a trace model.
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        run = 1'b0;
   logic [15:0] ir = 16'h0;
   logic [15:0] acc = 16'h0;
   logic        pc_write, pc_src, mar_write, mar_src, mbr_write, mbr_src;
   logic        ir_write, acc_write, mem_write_enable, halted, illegal_opcode;
   logic [1:0]  acc_src;
   logic [3:0]  alu_opcode;
   logic [15:0] word;

   localparam logic [15:0] W_PCW = 16'h8000, W_PCS = 16'h4000, W_MARW = 16'h2000, W_MARS = 16'h1000;
   localparam logic [15:0] W_MBRW = 16'h0800, W_MBRS = 16'h0400, W_IRW = 16'h0200, W_ACCW = 16'h0100;
   localparam logic [15:0] W_ACC_ZERO = 16'h0080, W_ACC_ALU = 16'h0040, W_ALU_SUB = 16'h0004;
   localparam logic [15:0] W_MWE = 16'h0002, W_HALT = 16'h0001;

   typedef struct {
      logic [15:0] ir;
      logic [15:0] acc;
      logic        ill;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_q[$];
   logic        exp_ill;

   always #5 clock = ~clock;

   control_sequencer dut (
      .clock(clock), .reset_n(reset_n), .run(run), .ir(ir), .acc(acc),
      .pc_write(pc_write), .pc_src(pc_src), .mar_write(mar_write), .mar_src(mar_src),
      .mbr_write(mbr_write), .mbr_src(mbr_src), .ir_write(ir_write), .acc_write(acc_write),
      .acc_src(acc_src), .alu_opcode(alu_opcode), .mem_write_enable(mem_write_enable),
      .halted(halted), .illegal_opcode(illegal_opcode)
   );

   assign word = {pc_write, pc_src, mar_write, mar_src, mbr_write, mbr_src, ir_write,
                  acc_write, acc_src, alu_opcode, mem_write_enable, halted};

   // Expected per-cycle control words for one instruction, from its first fetch cycle up to
   // (not including) the next fetch, or ending in the halted cycle.
   function automatic void build(input logic [15:0] i, input logic [15:0] a);
      int   s;
      logic skip;
      s = int'($signed(a));
      skip = i[11:10] == 2'd0 ? s < 0 : i[11:10] == 2'd1 ? s == 0 : i[11:10] == 2'd2 ? s > 0 : 1'b0;
      exp_q = {};
      exp_ill = 1'b0;
      exp_q.push_back(W_MARW);
      exp_q.push_back(16'h0);
      exp_q.push_back(W_IRW | W_PCW);
      case (i[15:12])
         4'h1, 4'h3, 4'h4: begin
            exp_q.push_back(16'h0);
            exp_q.push_back(W_MARW | W_MARS);
            exp_q.push_back(16'h0);
            exp_q.push_back(W_MBRW);
            exp_q.push_back(i[15:12] == 4'h1 ? W_ACCW :
                            i[15:12] == 4'h3 ? W_ACCW | W_ACC_ALU : W_ACCW | W_ACC_ALU | W_ALU_SUB);
         end
         4'h2: begin
            exp_q.push_back(W_MARW | W_MARS | W_MBRW | W_MBRS);
            exp_q.push_back(16'h0);
            exp_q.push_back(W_MWE);
         end
         4'h8: exp_q.push_back(skip ? W_PCW : 16'h0);
         4'h9: exp_q.push_back(W_PCW | W_PCS);
         4'hA: exp_q.push_back(W_ACCW | W_ACC_ZERO);
         4'h7: begin
            exp_q.push_back(16'h0);
            exp_q.push_back(W_HALT);
         end
         default: begin
            exp_q.push_back(16'h0);
            exp_q.push_back(W_HALT);
            exp_ill = 1'b1;
         end
      endcase
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Entered and left at the falling edge of a fetch (F_MAR) cycle.
   task automatic run_instr(input logic [15:0] i, input logic [15:0] a, input logic ill, input bit rnd);
      bit h;
      ir = i;
      acc = a;
      build(i, a);
      h = exp_q[exp_q.size()-1] == W_HALT;
      for (int c = 0; c < exp_q.size(); c++) begin
         if (c > 0) @(negedge clock);
         run = (rnd && !(h && c == exp_q.size()-1)) ? 1'($urandom_range(1)) : 1'b0;
         chk($sformatf("ir=%h cycle%0d", i, c+1), word, exp_q[c]);
      end
      chk($sformatf("ir=%h illegal", i), {15'b0, illegal_opcode}, {15'b0, ill});
      if (h) begin
         @(negedge clock);
         chk("halt_hold", word, W_HALT);
         chk("illegal_hold", {15'b0, illegal_opcode}, {15'b0, ill});
         run = 1'b1;
         @(negedge clock);
         run = 1'b0;
         chk("illegal_clear", {15'b0, illegal_opcode}, 16'h0);
      end else begin
         @(negedge clock);
      end
   endtask

   initial begin
      vec_t        tbl[$];
      logic [3:0]  legal[7];
      logic [3:0]  op;
      logic [15:0] i, a;
      legal = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA};
      tbl.push_back('{16'h1005, 16'h0000, 1'b0});
      tbl.push_back('{16'h4010, 16'h0007, 1'b0});
      tbl.push_back('{16'h3007, 16'h1234, 1'b0});
      tbl.push_back('{16'h2010, 16'h5555, 1'b0});
      tbl.push_back('{16'h8400, 16'h0000, 1'b0});
      tbl.push_back('{16'h8400, 16'h0003, 1'b0});
      tbl.push_back('{16'h8000, 16'hFFFF, 1'b0});
      tbl.push_back('{16'h8000, 16'h7FFF, 1'b0});
      tbl.push_back('{16'h8800, 16'h0003, 1'b0});
      tbl.push_back('{16'h8800, 16'h8000, 1'b0});
      tbl.push_back('{16'h8C00, 16'h0000, 1'b0});
      tbl.push_back('{16'h9123, 16'h0000, 1'b0});
      tbl.push_back('{16'hA000, 16'hFFFF, 1'b0});
      tbl.push_back('{16'hF000, 16'h0000, 1'b1});
      tbl.push_back('{16'h1005, 16'h0000, 1'b0});
      tbl.push_back('{16'h7000, 16'h0000, 1'b0});
      tbl.push_back('{16'h0000, 16'h0000, 1'b1});

      repeat (2) @(negedge clock);
      chk("reset_outputs", word, 16'h0);
      chk("reset_illegal", {15'b0, illegal_opcode}, 16'h0);
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clock);
         chk("idle_no_run", word, 16'h0);
      end
      run = 1'b1;
      @(negedge clock);
      run = 1'b0;

      foreach (tbl[k]) run_instr(tbl[k].ir, tbl[k].acc, tbl[k].ill, 1'b0);

      for (int n = 0; n < 80; n++) begin
         int r;
         r = int'($urandom_range(0, 15));
         op = r < 13 ? legal[r % 7] : 4'($urandom_range(0, 15));
         i = {op, 12'($urandom)};
         case ($urandom_range(0, 4))
            0: a = 16'h0000;
            1: a = 16'hFFFF;
            2: a = 16'h8000;
            3: a = 16'h0001;
            default: a = 16'($urandom);
         endcase
         build(i, a);
         run_instr(i, a, exp_ill, 1'b1);
      end

      // reset while a STORE waits for its memory write: the write must never appear
      run = 1'b0;
      ir = 16'h2010;
      repeat (4) @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("rst_xwait_outputs", word, 16'h0);
      repeat (3) begin
         @(negedge clock);
         chk("rst_no_mwe", {15'b0, mem_write_enable}, 16'h0);
         chk("rst_held_outputs", word, 16'h0);
      end
      reset_n = 1'b1;
      @(negedge clock);
      chk("rst_release_idle", word, 16'h0);
      @(negedge clock);
      chk("rst_idle_no_mwe", word, 16'h0);

      // asynchronous assertion mid-cycle drops an active MBR load at once
      ir = 16'h1005;
      run = 1'b1;
      @(negedge clock);
      run = 1'b0;
      repeat (6) @(negedge clock);
      chk("pre_rst_xmbr", word, W_MBRW);
      reset_n = 1'b0;
      #1;
      chk("rst_async_outputs", word, 16'h0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("rst_async_idle", word, 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
